// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: counter encodings,
// allocation state, next-state helper and index/tag width derivation.
package branch_predictor_pkg;

  // 2-bit saturating direction counter
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // State given to a freshly allocated entry (first taken resolution)
  localparam ctr_e ALLOC_CTR = WT;

  // Index width for a power-of-two table depth
  function automatic int bp_idxw(input int entries);
    return $clog2(entries);
  endfunction

  // Tag covers everything above the index and the ignored byte offset
  function automatic int bp_tagw(input int xlen, input int entries);
    return xlen - $clog2(entries) - 2;
  endfunction

  // Saturating counter step toward the resolved direction
  function automatic ctr_e ctr_step(input ctr_e c, input logic taken);
    ctr_e n;
    case (c)
      SNT:     n = taken ? WNT : SNT;
      WNT:     n = taken ? WT  : SNT;
      WT:      n = taken ? ST  : WNT;
      default: n = taken ? ST  : WT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/branch_predictor_table.sv
// Direct-mapped predictor storage: one synchronous write port and two
// asynchronous read ports (fetch lookup and execute update-hit check).
module branch_predictor_table
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int XLEN    = 32,
  parameter int IDXW    = bp_idxw(ENTRIES),
  parameter int TAGW    = bp_tagw(XLEN, ENTRIES)
) (
  input  logic            clk,
  input  logic            rst,
  // lookup read port
  input  logic [IDXW-1:0] i_lk_idx,
  output logic            o_lk_valid,
  output logic [TAGW-1:0] o_lk_tag,
  output logic [XLEN-1:0] o_lk_target,
  output ctr_e            o_lk_ctr,
  // update read port
  input  logic [IDXW-1:0] i_up_idx,
  output logic            o_up_valid,
  output logic [TAGW-1:0] o_up_tag,
  output logic [XLEN-1:0] o_up_target,
  output ctr_e            o_up_ctr,
  // write port
  input  logic            i_we,
  input  logic [IDXW-1:0] i_wr_idx,
  input  logic [TAGW-1:0] i_wr_tag,
  input  logic [XLEN-1:0] i_wr_target,
  input  ctr_e            i_wr_ctr
);

  logic [ENTRIES-1:0] r_valid;
  ctr_e               r_ctr    [ENTRIES];
  logic [TAGW-1:0]    r_tag    [ENTRIES];
  logic [XLEN-1:0]    r_target [ENTRIES];

  assign o_lk_valid  = r_valid[i_lk_idx];
  assign o_lk_tag    = r_tag[i_lk_idx];
  assign o_lk_target = r_target[i_lk_idx];
  assign o_lk_ctr    = r_ctr[i_lk_idx];

  assign o_up_valid  = r_valid[i_up_idx];
  assign o_up_tag    = r_tag[i_up_idx];
  assign o_up_target = r_target[i_up_idx];
  assign o_up_ctr    = r_ctr[i_up_idx];

  // Control state: valid bits and direction counters, cleared on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= SNT;
    end else if (i_we) begin
      r_valid[i_wr_idx] <= 1'b1;
      r_ctr[i_wr_idx]   <= i_wr_ctr;
    end
  end

  // Payload: tag and target, only meaningful behind a valid bit
  always_ff @(posedge clk) begin
    if (i_we && !rst) begin
      r_tag[i_wr_idx]    <= i_wr_tag;
      r_target[i_wr_idx] <= i_wr_target;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: registered direction/target prediction,
// training from execute-stage resolutions, and perf counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lookup_valid,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_valid,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            update_valid,
  input  logic [XLEN-1:0] update_pc,
  input  logic            update_taken,
  input  logic [XLEN-1:0] update_target,
  input  logic            update_pred_taken,
  input  logic [XLEN-1:0] update_pred_target,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  localparam int IDXW = bp_idxw(ENTRIES);
  localparam int TAGW = bp_tagw(XLEN, ENTRIES);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [IDXW-1:0] w_lk_idx, w_up_idx;
  logic [TAGW-1:0] w_lk_tag, w_up_tag;
  logic            w_lk_valid, w_up_valid;
  logic [TAGW-1:0] w_lk_tag_rd, w_up_tag_rd;
  logic [XLEN-1:0] w_lk_target, w_up_target;
  ctr_e            w_lk_ctr, w_up_ctr;
  logic            w_lk_hit, w_up_hit, w_lk_taken;
  logic            w_we;
  ctr_e            w_wr_ctr;
  logic [XLEN-1:0] w_wr_target;
  logic            w_mispredict;
  logic            w_unused_bits;

  logic            r_pred_valid, r_pred_taken;
  logic [XLEN-1:0] r_pred_target;
  logic [31:0]     r_branch_count, r_mispredict_count;

  assign w_lk_idx = lookup_pc[IDXW+1:2];
  assign w_lk_tag = lookup_pc[XLEN-1:IDXW+2];
  assign w_up_idx = update_pc[IDXW+1:2];
  assign w_up_tag = update_pc[XLEN-1:IDXW+2];

  // Byte-offset bits and the low counter bit on the lookup side carry no information here
  assign w_unused_bits = ^{lookup_pc[1:0], update_pc[1:0], w_lk_ctr[0]};

  branch_predictor_table #(
    .ENTRIES (ENTRIES),
    .XLEN    (XLEN)
  ) u_table (
    .clk         (clk),
    .rst         (rst),
    .i_lk_idx    (w_lk_idx),
    .o_lk_valid  (w_lk_valid),
    .o_lk_tag    (w_lk_tag_rd),
    .o_lk_target (w_lk_target),
    .o_lk_ctr    (w_lk_ctr),
    .i_up_idx    (w_up_idx),
    .o_up_valid  (w_up_valid),
    .o_up_tag    (w_up_tag_rd),
    .o_up_target (w_up_target),
    .o_up_ctr    (w_up_ctr),
    .i_we        (w_we),
    .i_wr_idx    (w_up_idx),
    .i_wr_tag    (w_up_tag),
    .i_wr_target (w_wr_target),
    .i_wr_ctr    (w_wr_ctr)
  );

  assign w_lk_hit   = w_lk_valid && (w_lk_tag_rd == w_lk_tag);
  assign w_lk_taken = w_lk_hit && w_lk_ctr[1];
  assign w_up_hit   = w_up_valid && (w_up_tag_rd == w_up_tag);

  // A not-taken miss leaves the table alone; every other resolution writes the entry
  assign w_we        = update_valid && (w_up_hit || update_taken);
  assign w_wr_ctr    = w_up_hit ? ctr_step(w_up_ctr, update_taken) : ALLOC_CTR;
  assign w_wr_target = update_taken ? update_target : w_up_target;

  assign w_mispredict = (update_pred_taken != update_taken) ||
                        (update_taken && (update_pred_target != update_target));

  // Registered prediction; taken/target hold while no lookup is presented
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pred_valid  <= 1'b0;
      r_pred_taken  <= 1'b0;
      r_pred_target <= '0;
    end else begin
      r_pred_valid <= lookup_valid;
      if (lookup_valid) begin
        r_pred_taken  <= w_lk_taken;
        r_pred_target <= w_lk_taken ? w_lk_target : lookup_pc + PC_STEP;
      end
    end
  end

  // Perf counters, free-running and wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else if (update_valid) begin
      r_branch_count <= r_branch_count + 32'd1;
      if (w_mispredict) r_mispredict_count <= r_mispredict_count + 32'd1;
    end
  end

  assign pred_valid       = r_pred_valid;
  assign pred_taken       = r_pred_taken;
  assign pred_target      = r_pred_target;
  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// randomized traffic, all compared against a behavioural table model.
module tb_branch_predictor;

  localparam int ENTRIES = 64;
  localparam int XLEN    = 32;
  localparam int IDXW    = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            lookup_valid;
  logic [XLEN-1:0] lookup_pc;
  logic            pred_valid, pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            update_valid, update_taken, update_pred_taken;
  logic [XLEN-1:0] update_pc, update_target, update_pred_target;
  logic [31:0]     branch_count, mispredict_count;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(ENTRIES), .XLEN(XLEN)) dut (
    .clk                (clk),
    .rst                (rst),
    .lookup_valid       (lookup_valid),
    .lookup_pc          (lookup_pc),
    .pred_valid         (pred_valid),
    .pred_taken         (pred_taken),
    .pred_target        (pred_target),
    .update_valid       (update_valid),
    .update_pc          (update_pc),
    .update_taken       (update_taken),
    .update_target      (update_target),
    .update_pred_taken  (update_pred_taken),
    .update_pred_target (update_pred_target),
    .branch_count       (branch_count),
    .mispredict_count   (mispredict_count)
  );

  // Behavioural model: table of entries with integer confidence 0..3
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  bit          e_pv, e_pt;
  logic [31:0] e_tgt, e_bc, e_mc;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  task automatic check_outputs(input string where);
    chk({where, ".pred_valid"},  64'(pred_valid),       64'(e_pv));
    chk({where, ".pred_taken"},  64'(pred_taken),       64'(e_pt));
    chk({where, ".pred_target"}, 64'(pred_target),      64'(e_tgt));
    chk({where, ".branch_cnt"},  64'(branch_count),     64'(e_bc));
    chk({where, ".mispred_cnt"}, 64'(mispredict_count), 64'(e_mc));
  endtask

  // One clock: drive inputs, predict from pre-update model state, train model, check
  task automatic step(input string where, input bit lv, input logic [31:0] lpc,
                      input bit uv, input logic [31:0] upc, input bit ut,
                      input logic [31:0] utgt, input bit upt, input logic [31:0] uptgt);
    int i;
    lookup_valid = lv; lookup_pc = lpc;
    update_valid = uv; update_pc = upc; update_taken = ut;
    update_target = utgt; update_pred_taken = upt; update_pred_target = uptgt;
    e_pv = lv;
    if (lv) begin
      i = idx_of(lpc);
      e_pt  = m_hit(lpc) && (m_ctr[i] >= 2);
      e_tgt = e_pt ? m_target[i] : lpc + 32'd4;
    end
    if (uv) begin
      e_bc = e_bc + 1;
      if (upt != ut || (ut && uptgt != utgt)) e_mc = e_mc + 1;
      i = idx_of(upc);
      if (m_hit(upc)) begin
        if (ut) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_target[i] = utgt;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (ut) begin
        m_valid[i] = 1; m_tag[i] = tag_of(upc); m_target[i] = utgt; m_ctr[i] = 2;
      end
    end
    @(posedge clk); #1;
    check_outputs(where);
  endtask

  task automatic look(input string where, input logic [31:0] pc);
    step(where, 1, pc, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic train(input string where, input logic [31:0] pc, input bit t, input logic [31:0] tgt);
    step(where, 0, 0, 1, pc, t, tgt, t, tgt);
  endtask

  // Reset with live lookup/update traffic to show reset dominates
  task automatic do_reset(input string where);
    rst = 1;
    lookup_valid = 1; lookup_pc = 32'h100;
    update_valid = 1; update_pc = 32'h100; update_taken = 1;
    update_target = 32'h80; update_pred_taken = 0; update_pred_target = 0;
    for (int i = 0; i < ENTRIES; i++) begin m_valid[i] = 0; m_ctr[i] = 0; end
    e_pv = 0; e_pt = 0; e_tgt = 0; e_bc = 0; e_mc = 0;
    @(posedge clk); #1;
    rst = 0;
    check_outputs(where);
  endtask

  initial begin
    rst = 1;
    lookup_valid = 0; lookup_pc = 0;
    update_valid = 0; update_pc = 0; update_taken = 0;
    update_target = 0; update_pred_taken = 0; update_pred_target = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset("reset");

    // Cold lookup
    look("t1", 32'h100);
    chk("t1.target_const", 64'(pred_target), 64'h104);

    // Allocate then hit
    train("t2.alloc", 32'h100, 1, 32'h80);
    look("t2", 32'h100);
    chk("t2.taken_const", 64'(pred_taken), 64'd1);
    chk("t2.target_const", 64'(pred_target), 64'h80);

    // Saturation walk: WT -> ST -> WT -> WNT -> ... -> ST, stays ST
    train("t3.up", 32'h100, 1, 32'h80);
    train("t3.dn1", 32'h100, 0, 32'h80);
    train("t3.dn2", 32'h100, 0, 32'h80);
    look("t3.wnt", 32'h100);
    chk("t3.wnt_const", 64'(pred_taken), 64'd0);
    for (int k = 0; k < 4; k++) train("t3.upk", 32'h100, 1, 32'h80);
    train("t3.dn3", 32'h100, 0, 32'h80);
    look("t3.st_to_wt", 32'h100);
    chk("t3.wt_const", 64'(pred_taken), 64'd1);

    // Alias eviction and no allocation on not-taken miss
    train("t4.alias", 32'h200, 1, 32'h300);
    look("t4.evicted", 32'h100);
    chk("t4.miss_const", 64'(pred_target), 64'h104);
    train("t4.nt_fresh", 32'h1230, 0, 32'h0);
    look("t4.nt_miss", 32'h1230);

    // Read-before-write in the same cycle
    step("t5.same", 1, 32'h40, 1, 32'h40, 1, 32'h500, 0, 0);
    chk("t5.rbw_const", 64'(pred_taken), 64'd0);
    look("t5.after", 32'h40);
    chk("t5.after_const", 64'(pred_taken), 64'd1);

    // Mispredict accounting
    do_reset("t6.reset");
    step("t6.a", 0, 0, 1, 32'h600, 0, 32'h10, 0, 32'h10);
    step("t6.b", 0, 0, 1, 32'h600, 1, 32'h10, 0, 32'h0);
    step("t6.c", 0, 0, 1, 32'h600, 1, 32'h10, 1, 32'h20);
    step("t6.d", 0, 0, 1, 32'h600, 1, 32'h10, 1, 32'h10);
    chk("t6.bc_const", 64'(branch_count), 64'd4);
    chk("t6.mc_const", 64'(mispredict_count), 64'd2);
    do_reset("t6.midreset");
    look("t6.post_reset", 32'h600);
    chk("t6.post_const", 64'(pred_target), 64'h604);

    // Randomized traffic over a small PC pool so hits, aliases and collisions occur
    for (int n = 0; n < 400; n++) begin
      logic [31:0] lpc, upc, utgt, ptgt;
      bit ut, pt;
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rnd.reset");
      end else begin
        lpc  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
        upc  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
        utgt = $urandom_range(0, 3) << 4;
        ut   = $urandom_range(0, 1);
        pt   = $urandom_range(0, 1);
        ptgt = $urandom_range(0, 1) ? utgt : ($urandom_range(0, 3) << 4);
        step("rnd", $urandom_range(0, 3) != 0, lpc, $urandom_range(0, 2) != 0, upc, ut, utgt, pt, ptgt);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
